grad_mag_ctrl: RTL
==================

// Module: grad_mag_ctrl
// PURPOSE
//   Sequencer for the 3-stage gradient datapath (sum_sq_diff) in the HOG front end.
//   - Accepts per-pixel neighbour tuples (top/bot/left/right) on a valid/ready stream.
//   - Drives the free-running datapath and tracks in-flight pixels with a valid shift register.
//   - Realigns the 1-cycle diffs with the 3-cycle magnitude and tags each result with col/row/eof.
//   - Buffers results in a credit-managed output FIFO, because the datapath cannot stall.
// PARAMETERS
//   PIX_W      8    pixel width
//   IMG_W      160  pixels per row
//   IMG_H      120  rows per frame
//   COORD_W    8    width of col/row counters (must hold IMG_W-1 and IMG_H-1)
//   FIFO_DEPTH 4    output FIFO entries (power of 2, >= 4)
// PORTS
//   clk         in   1          clock, rising edge
//   rst_n       in   1          async active-low reset
//   start       in   1          begin a frame (sampled in IDLE only)
//   busy        out  1          high in RUN or DRAIN
//   done        out  1          1-cycle pulse at end of frame
//   in_valid    in   1          neighbour tuple valid
//   in_ready    out  1          tuple accepted when in_valid & in_ready
//   in_top/bot/left/right in PIX_W   neighbour pixels
//   dp_top/bot/left/right out PIX_W  to datapath; combinational copy of in_*
//   dp_ver_diff in   PIX_W+1    datapath bot-top, signed, valid at T+1
//   dp_hor_diff in   PIX_W+1    datapath right-left, signed, valid at T+1
//   dp_result   in   2*PIX_W+1  datapath ver^2+hor^2, valid at T+3
//   out_valid   out  1          FIFO non-empty
//   out_ready   in   1          downstream pop
//   out_mag     out  2*PIX_W+1  squared magnitude
//   out_ver/out_hor out PIX_W+1 signed diffs aligned with out_mag
//   out_col/out_row out COORD_W pixel coordinates
//   out_eof     out  1          last pixel of the frame
// BEHAVIOUR
//   - Reset: state=IDLE; all counters, valid shift register and FIFO cleared.
//     busy=done=in_ready=out_valid=out_eof=0; all out_* data=0.
//   - FSM:
//     IDLE  -> RUN on start.
//     RUN   -> DRAIN on the cycle the tuple at (IMG_W-1, IMG_H-1) is accepted.
//     DRAIN -> DONE when valid shift register and FIFO are both empty.
//     DONE  -> IDLE after 1 cycle; done=1 only in DONE.
//     start outside IDLE is ignored.
//   - in_ready = (state==RUN) && (fifo_count + inflight < FIFO_DEPTH).
//     inflight = popcount of the 3-bit valid shift register.
//     A same-cycle pop is not credited (conservative); a FIFO overflow is impossible by construction.
//   - fire = in_valid & in_ready. fire is shifted through a 3-stage valid shift register.
//     Sideband (col, row, eof) travels with fire through 3 stages.
//   - dp_ver/hor_diff are captured at stage 1 and delayed 2 cycles, to align with dp_result at stage 3.
//   - Stage-3 valid pushes {mag, ver, hor, col, row, eof} into the FIFO.
//     Datapath outputs on cycles without valid are discarded.
//   - Coordinates on fire:
//     col increments; at IMG_W-1 col wraps to 0 and row increments.
//     eof=1 at (IMG_W-1, IMG_H-1). Both counters clear on entering RUN.
//   - FIFO:
//     First-word-fall-through. out_* reflects the head entry while out_valid=1.
//     Simultaneous push and pop keeps the count unchanged.
//     Pop on empty is ignored. Output order equals input order.
//   - Latency: fire at cycle T -> out_valid at T+4 if the FIFO was empty (3 pipe + 1 write).
//   - in_valid is ignored outside RUN. in_* need not be held when in_ready=0.
//   - Async reset mid-frame discards all in-flight and buffered pixels. The next start begins at (0,0).
// TESTING
//   1. start; one tuple top=10 bot=30 left=5 right=9
//      -> out_mag=416, out_ver=20, out_hor=4, col=0, row=0, 4 cycles after fire.
//   2. top=200 bot=0 left=255 right=0
//      -> out_ver=-200, out_hor=-255, out_mag=105025 (no truncation).
//   3. out_ready=0 with in_valid held high
//      -> exactly 4 tuples accepted, then in_ready=0.
//      Release -> the 4 results pop in order, streaming resumes, no loss or duplicate.
//   4. IMG_W=4, IMG_H=2, continuous stream with random out_ready
//      -> 8 outputs; col wraps 3->0 with row 0->1; out_eof only on the 8th.
//      done pulses once after the final pop; back to IDLE.
//   5. rst_n low mid-frame with FIFO non-empty
//      -> out_valid=0, busy=0 immediately. A new start restarts at col=0, row=0.
//   6. start pulsed during RUN, and in_valid in IDLE
//      -> both ignored; in_ready=0 in IDLE; the frame count is unaffected.

Source files
------------

// File: rtl/grad_mag_ctrl_if.sv
// Stream/datapath bundle for grad_mag_ctrl: neighbour-tuple input stream,
// connection to the free-running sum_sq_diff datapath, and the tagged
// result stream. The controller uses the slave view, the environment the master.
interface grad_mag_ctrl_if #(
  parameter int PIX_W   = 8,
  parameter int COORD_W = 8
);
  // Input tuple stream
  logic                    in_valid;
  logic                    in_ready;
  logic [PIX_W-1:0]        in_top;
  logic [PIX_W-1:0]        in_bot;
  logic [PIX_W-1:0]        in_left;
  logic [PIX_W-1:0]        in_right;
  // Datapath connection
  logic [PIX_W-1:0]        dp_top;
  logic [PIX_W-1:0]        dp_bot;
  logic [PIX_W-1:0]        dp_left;
  logic [PIX_W-1:0]        dp_right;
  logic signed [PIX_W:0]   dp_ver_diff;
  logic signed [PIX_W:0]   dp_hor_diff;
  logic [2*PIX_W:0]        dp_result;
  // Result stream
  logic                    out_valid;
  logic                    out_ready;
  logic [2*PIX_W:0]        out_mag;
  logic signed [PIX_W:0]   out_ver;
  logic signed [PIX_W:0]   out_hor;
  logic [COORD_W-1:0]      out_col;
  logic [COORD_W-1:0]      out_row;
  logic                    out_eof;

  modport slave (
    input  in_valid, in_top, in_bot, in_left, in_right,
    output in_ready,
    output dp_top, dp_bot, dp_left, dp_right,
    input  dp_ver_diff, dp_hor_diff, dp_result,
    output out_valid, out_mag, out_ver, out_hor, out_col, out_row, out_eof,
    input  out_ready
  );

  modport master (
    output in_valid, in_top, in_bot, in_left, in_right,
    input  in_ready,
    input  dp_top, dp_bot, dp_left, dp_right,
    output dp_ver_diff, dp_hor_diff, dp_result,
    input  out_valid, out_mag, out_ver, out_hor, out_col, out_row, out_eof,
    output out_ready
  );
endinterface

// File: rtl/grad_mag_ctrl.sv
// Sequencer for the 3-stage gradient datapath in the HOG front end.
// Feeds neighbour tuples to the free-running datapath, tracks in-flight
// pixels, realigns the early diffs with the late magnitude, tags each result
// with col/row/eof and buffers it in a credit-managed FWFT FIFO.
module grad_mag_ctrl #(
  parameter int PIX_W      = 8,
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int COORD_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  grad_mag_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic               eof;
  } side_t;

  typedef struct packed {
    logic [2*PIX_W:0]      mag;
    logic signed [PIX_W:0] ver;
    logic signed [PIX_W:0] hor;
    side_t                 side;
  } entry_t;

  state_t                state_q, state_d;
  logic [COORD_W-1:0]    col_q, row_q;
  logic [2:0]            vld_q;
  side_t                 side_q [3];
  logic signed [PIX_W:0] ver_q [2];
  logic signed [PIX_W:0] hor_q [2];
  entry_t                mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W:0]        used;
  logic                  in_ready, fire, last_pix, push, pop, fifo_ne;
  entry_t                head;

  // Datapath is fed straight from the input tuple
  assign bus.dp_top   = bus.in_top;
  assign bus.dp_bot   = bus.in_bot;
  assign bus.dp_left  = bus.in_left;
  assign bus.dp_right = bus.in_right;

  assign last_pix = (col_q == COORD_W'(IMG_W - 1)) && (row_q == COORD_W'(IMG_H - 1));

  // Credit: a slot is reserved for every pixel still in the pipe; pops in the
  // same cycle are not counted, so the FIFO can never overflow.
  assign used = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(vld_q[0])
              + (CNT_W+1)'(vld_q[1]) + (CNT_W+1)'(vld_q[2]);
  assign in_ready     = (state_q == S_RUN) && (used < (CNT_W+1)'(FIFO_DEPTH));
  assign fire         = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and status outputs
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN: begin
        busy_o = 1'b1;
        if (fire && last_pix) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        if (vld_q == '0 && !fifo_ne) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel coordinates: cleared on frame start, advanced per accepted tuple
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (fire) begin
      if (col_q == COORD_W'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= row_q + COORD_W'(1);
      end else begin
        col_q <= col_q + COORD_W'(1);
      end
    end
  end

  // Valid/sideband pipe; diffs captured one cycle after fire and delayed two
  // more so they meet dp_result at stage 3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < 3; i++) side_q[i] <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        ver_q[i] <= '0;
        hor_q[i] <= '0;
      end
    end else begin
      vld_q     <= {vld_q[1:0], fire};
      side_q[0] <= '{col: col_q, row: row_q, eof: last_pix};
      side_q[1] <= side_q[0];
      side_q[2] <= side_q[1];
      ver_q[0]  <= bus.dp_ver_diff;
      ver_q[1]  <= ver_q[0];
      hor_q[0]  <= bus.dp_hor_diff;
      hor_q[1]  <= hor_q[0];
    end
  end

  assign push    = vld_q[2];
  assign fifo_ne = (cnt_q != '0);
  assign pop     = fifo_ne && bus.out_ready;

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents only matter behind a valid occupancy count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{mag: bus.dp_result, ver: ver_q[1], hor: hor_q[1], side: side_q[2]};
  end

  // First-word-fall-through head, forced to zero while empty
  always_comb begin
    head          = mem_q[rd_ptr_q];
    bus.out_valid = fifo_ne;
    bus.out_mag   = fifo_ne ? head.mag      : '0;
    bus.out_ver   = fifo_ne ? head.ver      : '0;
    bus.out_hor   = fifo_ne ? head.hor      : '0;
    bus.out_col   = fifo_ne ? head.side.col : '0;
    bus.out_row   = fifo_ne ? head.side.row : '0;
    bus.out_eof   = fifo_ne && head.side.eof;
  end

endmodule
